// File: rtl/adsr_envelope.sv
// ADSR envelope generator with signed amplitude scaling of the oscillator sample.
// Build option: define ADSR_EXP_RELEASE_EN for an exponential-style release.
module adsr_envelope #(
  parameter int DATA_W = 16,
  parameter int ENV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_gate,
  input  logic [ENV_W-1:0]  i_attack_rate,
  input  logic [ENV_W-1:0]  i_decay_rate,
  input  logic [ENV_W-1:0]  i_sustain,
  input  logic [ENV_W-1:0]  i_release_rate,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ENV_W-1:0]  o_env,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_e;

  localparam int PROD_W = DATA_W + ENV_W + 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  state_e state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic gate_q, gate_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;

  logic rise, fall;
  logic [ENV_W:0] att_sum;
  logic signed [ENV_W:0] dec_diff;
  logic rel_done;
  logic [ENV_W-1:0] rel_next;

  logic [PROD_W-1:0] data_x, env_x;
  logic signed [PROD_W-1:0] prod, prod_sh;
  logic [PROD_W-DATA_W-1:0] unused_prod_hi;

  // Scale by the level held before this strobe's update.
  always_comb begin
    data_x = {{(ENV_W+1){i_data[DATA_W-1]}}, i_data};
    env_x = {{DATA_W{1'b0}}, env_q};
    prod = $signed(data_x) * $signed(env_x);
    prod_sh = prod >>> ENV_W;
    unused_prod_hi = prod_sh[PROD_W-1:DATA_W];
  end

`ifdef ADSR_EXP_RELEASE_EN
  localparam logic [ENV_W:0] STEP_ONE = 1;
  logic [2*ENV_W-1:0] rel_prod;
  logic [ENV_W:0] rel_step;
  logic [ENV_W-1:0] unused_rel_lo;

  always_comb begin
    rel_prod = {{ENV_W{1'b0}}, env_q}
             * {{ENV_W{1'b0}}, i_release_rate};
    rel_step = {1'b0, rel_prod[2*ENV_W-1:ENV_W]} + STEP_ONE;
    unused_rel_lo = rel_prod[ENV_W-1:0];
    rel_done = rel_step >= {1'b0, env_q};
    rel_next = env_q - rel_step[ENV_W-1:0];
  end
`else
  always_comb begin
    rel_done = env_q <= i_release_rate;
    rel_next = env_q - i_release_rate;
  end
`endif

  always_comb begin
    state_d = state_q;
    env_d = env_q;
    gate_d = gate_q;
    data_d = data_q;
    valid_d = 1'b0;
    rise = i_gate & ~gate_q;
    fall = ~i_gate & gate_q;
    att_sum = {1'b0, env_q} + {1'b0, i_attack_rate};
    dec_diff = $signed({1'b0, env_q}) - $signed({1'b0, i_decay_rate});
    if (i_sample_en) begin
      gate_d = i_gate;
      valid_d = 1'b1;
      data_d = prod_sh[DATA_W-1:0];
      unique case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_ATTACK;
        end
        S_ATTACK: begin
          if (fall) begin
            state_d = S_RELEASE;
          end else if (att_sum >= {1'b0, ENV_MAX}) begin
            env_d = ENV_MAX;
            state_d = S_DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        S_DECAY: begin
          if (fall) begin
            state_d = S_RELEASE;
          end else if (dec_diff <= $signed({1'b0, i_sustain})) begin
            env_d = i_sustain;
            state_d = S_SUSTAIN;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
        S_SUSTAIN: begin
          if (fall) state_d = S_RELEASE;
          else env_d = i_sustain;
        end
        S_RELEASE: begin
          // Re-trigger resumes attack from the current level.
          if (rise) begin
            state_d = S_ATTACK;
          end else if (rel_done) begin
            env_d = '0;
            state_d = S_IDLE;
          end else begin
            env_d = rel_next;
          end
        end
        default: begin
          state_d = S_IDLE;
          env_d = '0;
        end
      endcase
    end
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      env_q <= '0;
      gate_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q <= env_d;
      gate_q <= gate_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end

  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_env = env_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: attack, decay, sustain, scaling, release, reset.
// Honours ADSR_EXP_RELEASE_EN for the release expectations.
module tb_adsr_envelope;

  localparam int DW = 16;
  localparam int EW = 16;
`ifdef ADSR_EXP_RELEASE_EN
  localparam logic [EW-1:0] REL_RATE = 16'h1000;
  localparam logic [EW-1:0] REL_FIRST = 16'h77FF;
`else
  localparam logic [EW-1:0] REL_RATE = 16'h0400;
  localparam logic [EW-1:0] REL_FIRST = 16'h7C00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sample_en, gate;
  logic [DW-1:0] data_in;
  logic [EW-1:0] att, dec, sus, rel;
  logic [DW-1:0] data_out;
  logic valid, busy;
  logic [EW-1:0] env;

  int n_checks = 0;
  int n_errors = 0;
  int n_steps;
  logic [EW-1:0] m_env;

  adsr_envelope #(.DATA_W(DW), .ENV_W(EW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_sample_en(sample_en),
    .i_data(data_in),
    .i_gate(gate),
    .i_attack_rate(att),
    .i_decay_rate(dec),
    .i_sustain(sus),
    .i_release_rate(rel),
    .o_data(data_out),
    .o_valid(valid),
    .o_env(env),
    .o_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Three idle clocks, then a one-cycle strobe; returns one clock after it.
  task automatic strobe();
    repeat (3) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  function automatic logic [EW-1:0] rel_model(input logic [EW-1:0] e,
                                              input logic [EW-1:0] r);
`ifdef ADSR_EXP_RELEASE_EN
    logic [31:0] s;
    s = ((32'(e) * 32'(r)) >> EW) + 32'd1;
    return (s >= 32'(e)) ? '0 : e - s[EW-1:0];
`else
    return (e <= r) ? '0 : e - r;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b0;
    gate = 1'b0;
    data_in = '0;
    att = 16'h1000;
    dec = 16'h0800;
    sus = 16'h8000;
    rel = REL_RATE;
    repeat (3) @(negedge clk);
    check("rst_env", env, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    rst_n = 1'b1;

    gate = 1'b1;
    data_in = 16'h4000;
    strobe();
    check("rise_env", env, 0);
    check("rise_busy", busy, 1);
    for (int k = 1; k <= 16; k++) begin
      strobe();
      check("att_env", env, (k < 16) ? k * 32'h1000 : 32'hFFFF);
      check("att_data", data_out, (k - 1) * 32'h400);
    end

    for (int k = 1; k <= 16; k++) begin
      strobe();
      check("dec_env", env, (k < 16) ? 32'hFFFF - k * 32'h800 : 32'h8000);
    end
    check("dec_busy", busy, 1);

    strobe();
    check("sus_hold", env, 16'h8000);
    sus = 16'h6000;
    strobe();
    check("sus_track", env, 16'h6000);
    sus = 16'h8000;
    strobe();
    check("sus_back", env, 16'h8000);

    data_in = 16'h4000;
    strobe();
    check("scale_pos", data_out, 16'h2000);
    check("valid_hi", valid, 1);
    @(negedge clk);
    check("valid_lo", valid, 0);
    data_in = 16'hC000;
    strobe();
    check("scale_neg", data_out, 16'hE000);

    gate = 1'b0;
    strobe();
    check("fall_env", env, 16'h8000);
    check("fall_busy", busy, 1);
    m_env = 16'h8000;
    n_steps = 0;
    while (m_env != 0 && n_steps < 400) begin
      strobe();
      m_env = rel_model(m_env, rel);
      n_steps++;
      if (n_steps == 1) check("rel_first", env, REL_FIRST);
      check("rel_env", env, m_env);
    end
    check("rel_idle_busy", busy, 0);
`ifndef ADSR_EXP_RELEASE_EN
    check("rel_steps", n_steps, 32);
`endif

    gate = 1'b1;
    strobe();
    check("rise2_env", env, 0);
    att = 16'h8000;
    strobe();
    check("att_big", env, 16'h8000);
    gate = 1'b0;
    strobe();
    m_env = 16'h8000;
    for (int k = 1; k <= 16; k++) begin
      strobe();
      m_env = rel_model(m_env, rel);
    end
    check("rel16_env", env, m_env);
    gate = 1'b1;
    att = 16'h1000;
    strobe();
    check("rerise_hold", env, m_env);
    check("rerise_busy", busy, 1);
    strobe();
    check("rerise_att", env, m_env + 16'h1000);
    att = 16'h0000;
    strobe();
    check("att_stall", env, m_env + 16'h1000);

    @(negedge clk);
    rst_n = 1'b0;
    sample_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sample_en = 1'b0;
    check("mid_rst_env", env, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", data_out, 0);

    att = 16'h1000;
    strobe();
    check("post_rst_rise", busy, 1);
    check("post_rst_env0", env, 0);
    strobe();
    check("post_rst_att", env, 16'h1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
